bus_arbiter8: RTL

Round-robin arbiter and sequencer for the shared 8-way, BUS_BITS-wide datapath mux. It accepts requests from eight producers and grants one at a time. It drives the mux select, holds the grant for a multi-beat transaction until the final beat is accepted, and then rotates priority. It is control-only: the parent instantiates the 8-input mux and connects `sel` to it.

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/rr_pick8.sv | 37 +++
 rtl/bus_arbiter8.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants and types for the 8-way round-robin bus arbiter.
// Included by the picker and the top level via import bus_arbiter_pkg::*.
package bus_arbiter_pkg;

    localparam int N_REQ    = 8;
    localparam int SEL_BITS = 3;
    localparam int CNT_BITS = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_BITS-1:0] s);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set bit of (req & ~mask)
// searching ptr, ptr+1, ... ptr+7 modulo 8.
module rr_pick8
    import bus_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0]    req,
    input  logic [SEL_BITS-1:0] ptr,
    input  logic [N_REQ-1:0]    mask,
    output logic                any,
    output logic [SEL_BITS-1:0] idx
);

    logic [N_REQ-1:0]    masked;
    logic [SEL_BITS-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign masked[gi] = req[gi] & ~mask[gi];
        end
    endgenerate

    // Walk from the farthest offset down so the nearest hit overwrites last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_BITS'(k);
            if (masked[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter/sequencer for an 8-way shared datapath mux: holds a grant
// for a multi-beat transaction, then rotates priority with no idle bubble.
module bus_arbiter8
    import bus_arbiter_pkg::*;
#(
    parameter int BUS_BITS  = 64,
    parameter int MAX_BEATS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    last,
    input  logic                ready,
    output logic [N_REQ-1:0]    gnt,
    output logic [SEL_BITS-1:0] sel,
    output logic                valid,
    output logic                err
);

    generate
        if (BUS_BITS < 1) begin : g_bad_bus
            $error("bus_arbiter8: BUS_BITS must be positive");
        end
        if (MAX_BEATS < 2 || MAX_BEATS > 255) begin : g_bad_beats
            $error("bus_arbiter8: MAX_BEATS must be in 2..255");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic [SEL_BITS-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                busy;
    logic                accept;
    logic                rel_abort;
    logic                rel_normal;
    logic                rel_wdog;
    logic                release_any;
    logic [SEL_BITS-1:0] pick_ptr;
    logic [N_REQ-1:0]    pick_mask;
    logic                pick_any;
    logic [SEL_BITS-1:0] pick_idx;

    assign busy   = (state_q == ST_BUSY);
    assign accept = busy && ready;

    // Abort outranks everything: a beat coinciding with a dropped req is not counted.
    assign rel_abort   = busy && !req[sel_q];
    assign rel_normal  = accept && !rel_abort && last[sel_q];
    assign rel_wdog    = accept && !rel_abort && !last[sel_q]
                         && (cnt_q == CNT_BITS'(MAX_BEATS - 1));
    assign release_any = rel_abort || rel_normal || rel_wdog;

    // On release the search restarts just past the outgoing owner.
    assign pick_ptr  = release_any ? (sel_q + SEL_BITS'(1)) : ptr_q;
    assign pick_mask = (rel_abort || rel_wdog) ? sel_onehot(sel_q) : '0;

    rr_pick8 u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .mask (pick_mask),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BUSY;
                    sel_d   = pick_idx;
                    gnt_d   = sel_onehot(pick_idx);
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (release_any) begin
                    ptr_d = pick_ptr;
                    err_d = rel_abort || rel_wdog;
                    cnt_d = '0;
                    if (pick_any) begin
                        sel_d = pick_idx;
                        gnt_d = sel_onehot(pick_idx);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = busy;
    assign err   = err_q;

endmodule
